// File: rtl/sum_table_pkg.sv
// Shared state type and sizing helpers for the adder lookup-table builder.
package sum_table_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    function automatic int addr_w(input int data_width);
        return 32'sd2 * data_width;
    endfunction

    function automatic int depth(input int data_width);
        return 32'sd1 <<< (32'sd2 * data_width);
    endfunction

endpackage

// File: rtl/sum_table_writer_if.sv
// Fill-control and lookup signals of the sum table builder.
// The master side requests fills and lookups; the slave side is the table.
interface sum_table_writer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                      start;
    logic                      busy;
    logic                      ready;
    logic                      done;
    logic [2*DATA_WIDTH-1:0]   fill_addr;
    logic                      rd_en;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic [DATA_WIDTH:0]       sum;
    logic                      sum_valid;

    modport master (
        output start, rd_en, a, b,
        input  busy, ready, done, fill_addr, sum, sum_valid
    );

    modport slave (
        input  start, rd_en, a, b,
        output busy, ready, done, fill_addr, sum, sum_valid
    );
endinterface

// File: rtl/sum_table_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read port.
// A same-address read and write return the new data; the read register holds when idle.
module sum_table_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 32'sd1 <<< ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage array write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next read-register value: write-first bypass, otherwise array contents.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_q[raddr];
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sum_table_writer.sv
// Builds an a+b lookup table in on-chip RAM by sweeping every {a,b} pair,
// then serves one-cycle-latency lookups from the table it wrote.
module sum_table_writer
    import sum_table_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sum_table_writer_if.slave bus
);
    localparam int AW    = addr_w(DATA_WIDTH);
    localparam int DEPTH = depth(DATA_WIDTH);
    localparam int SW    = DATA_WIDTH + 1;

    localparam logic [AW-1:0] ADDR_ONE  = AW'(32'd1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(DEPTH - 2);

    state_t          state_d,     state_q;
    logic [AW-1:0]   fill_addr_d, fill_addr_q;
    logic            busy_d,      busy_q;
    logic            ready_d,     ready_q;
    logic            done_d,      done_q;
    logic            sum_valid_d, sum_valid_q;

    logic            we_s;
    logic [SW-1:0]   wdata_s;
    logic            re_s;
    logic [AW-1:0]   raddr_s;
    logic [SW-1:0]   rdata_s;

    // Fill sequencing: next state, write index and status flags.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (bus.start) begin
                    state_d     = FILL;
                    fill_addr_d = {AW{1'b0}};
                    busy_d      = 1'b1;
                    ready_d     = 1'b0;
                end else begin
                    state_d = EMPTY;
                end
            end
            FILL: begin
                // start is ignored here; the index wraps to zero after the last entry
                fill_addr_d = fill_addr_q + ADDR_ONE;
                if (fill_addr_q == LAST_ADDR) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else if (fill_addr_q == PRE_LAST) begin
                    done_d = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end
            READY: begin
                if (bus.start) begin
                    state_d     = FILL;
                    fill_addr_d = {AW{1'b0}};
                    busy_d      = 1'b1;
                    ready_d     = 1'b0;
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d     = EMPTY;
                fill_addr_d = {AW{1'b0}};
                busy_d      = 1'b0;
                ready_d     = 1'b0;
            end
        endcase
    end

    // Table write port and lookup acceptance.
    always_comb begin
        we_s        = (state_q == FILL);
        wdata_s     = {1'b0, fill_addr_q[AW-1:DATA_WIDTH]} + {1'b0, fill_addr_q[DATA_WIDTH-1:0]};
        re_s        = bus.rd_en & ready_q;
        raddr_s     = {bus.a, bus.b};
        sum_valid_d = re_s;
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            fill_addr_q <= {AW{1'b0}};
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    sum_table_ram #(
        .ADDR_W (AW),
        .DATA_W (SW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (fill_addr_q),
        .wdata (wdata_s),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    assign bus.busy      = busy_q;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.fill_addr = fill_addr_q;
    assign bus.sum       = rdata_s;
    assign bus.sum_valid = sum_valid_q;

endmodule

// File: tb/tb_sum_table_writer.sv
// Directed-plus-random bench for sum_table_writer at DATA_WIDTH 4, 1 and 8,
// checked against a plain a+b model with a ready flag and a held-sum register.
module tb_sum_table_writer;

    logic clk = 1'b0;
    logic rst4;
    logic rst_x;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done8  = 0;
    bit   model_ready = 1'b0;
    int   exp_sum  = 0;

    always #5 clk = ~clk;

    sum_table_writer_if #(.DATA_WIDTH(4)) s4 ();
    sum_table_writer_if #(.DATA_WIDTH(1)) s1 ();
    sum_table_writer_if #(.DATA_WIDTH(8)) s8 ();

    sum_table_writer #(.DATA_WIDTH(4)) dut4 (.clk(clk), .rst(rst4),  .bus(s4));
    sum_table_writer #(.DATA_WIDTH(1)) dut1 (.clk(clk), .rst(rst_x), .bus(s1));
    sum_table_writer #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst(rst_x), .bus(s8));

    always @(negedge clk) begin
        if (s8.done === 1'b1) n_done8 <= n_done8 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic lookup4(input logic [3:0] la, input logic [3:0] lb, input string tag);
        s4.rd_en = 1'b1; s4.a = la; s4.b = lb;
        tick();
        s4.rd_en = 1'b0;
        exp_sum = int'(la) + int'(lb);
        check(tag, {26'd0, s4.sum_valid, s4.sum}, 32'(32 + exp_sum));
    endtask

    task automatic rand_phase4(input int n);
        logic       rd;
        logic [3:0] ra, rb;
        int         exp_v;
        for (int i = 0; i < n; i++) begin
            rd = 1'($urandom); ra = 4'($urandom); rb = 4'($urandom);
            s4.rd_en = rd; s4.a = ra; s4.b = rb;
            tick();
            if (rd && model_ready) begin
                exp_sum = int'(ra) + int'(rb);
                exp_v = 1;
            end else begin
                exp_v = 0;
            end
            check("rand_lookup", {26'd0, s4.sum_valid, s4.sum}, 32'((exp_v << 5) | exp_sum));
        end
        s4.rd_en = 1'b0;
    endtask

    // Fill observed cycle by cycle; cycle 1 is the first cycle after start is sampled.
    task automatic fill4(input bit with_lookup, input int start_again_at);
        int         done_cycle, n_done, ready_cycle, blocked_bad, addr_bad;
        logic [4:0] held;
        done_cycle = -1; n_done = 0; ready_cycle = -1; blocked_bad = 0; addr_bad = 0;
        s4.start = 1'b1; s4.rd_en = with_lookup; s4.a = 4'd7; s4.b = 4'd9;
        tick();
        s4.start = 1'b0;
        if (with_lookup) begin
            exp_sum = 7 + 9;
            check("start_cycle_lookup", {26'd0, s4.sum_valid, s4.sum}, 32'(32 + exp_sum));
            check("ready_low_after_start", {31'd0, s4.ready}, 32'd0);
        end
        check("fill_busy_c1", {31'd0, s4.busy}, 32'd1);
        held = s4.sum;
        s4.rd_en = 1'b1; s4.a = 4'd3; s4.b = 4'd4;
        for (int k = 1; k <= 300; k++) begin
            if (s4.done === 1'b1) begin n_done++; done_cycle = k; end
            if (k > 1 && (s4.sum_valid !== 1'b0 || s4.sum !== held)) blocked_bad++;
            if (s4.ready === 1'b1) begin ready_cycle = k; break; end
            if (s4.busy !== 1'b1 || s4.fill_addr !== 8'(k - 1)) addr_bad++;
            s4.start = (k == start_again_at);
            tick();
        end
        s4.rd_en = 1'b0; s4.start = 1'b0;
        check("done_cycle",       32'(done_cycle),  32'd256);
        check("done_pulse_count", 32'(n_done),      32'd1);
        check("ready_cycle",      32'(ready_cycle), 32'd257);
        check("busy_after_fill",  {31'd0, s4.busy}, 32'd0);
        check("fill_addr_wrap",   {24'd0, s4.fill_addr}, 32'd0);
        check("blocked_reads",    32'(blocked_bad), 32'd0);
        check("fill_addr_track",  32'(addr_bad),    32'd0);
        model_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] mask, p;
        logic [1:0] p1;
        logic [7:0] ra8, rb8;
        int         done1, ready1;

        rst4 = 1'b1; rst_x = 1'b1;
        s4.start = 1'b0; s4.rd_en = 1'b0; s4.a = 4'd0; s4.b = 4'd0;
        s1.start = 1'b0; s1.rd_en = 1'b0; s1.a = 1'd0; s1.b = 1'd0;
        s8.start = 1'b0; s8.rd_en = 1'b0; s8.a = 8'd0; s8.b = 8'd0;
        tick();
        tick();
        check("rst_busy",      {31'd0, s4.busy},      32'd0);
        check("rst_ready",     {31'd0, s4.ready},     32'd0);
        check("rst_done",      {31'd0, s4.done},      32'd0);
        check("rst_fill_addr", {24'd0, s4.fill_addr}, 32'd0);
        check("rst_sum",       {27'd0, s4.sum},       32'd0);
        check("rst_sum_valid", {31'd0, s4.sum_valid}, 32'd0);
        rst4 = 1'b0; rst_x = 1'b0;

        // The wide table fills in the background while the narrower ones are exercised.
        s8.start = 1'b1;
        tick();
        s8.start = 1'b0;

        rand_phase4(20);
        fill4(1'b0, 100);

        mask = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            p = 8'(i) ^ mask;
            s4.rd_en = 1'b1; s4.a = p[7:4]; s4.b = p[3:0];
            tick();
            exp_sum = int'(p[7:4]) + int'(p[3:0]);
            check("sweep", {26'd0, s4.sum_valid, s4.sum}, 32'(32 + exp_sum));
        end
        s4.rd_en = 1'b0;
        lookup4(4'd15, 4'd15, "spot_15_15");
        lookup4(4'd0,  4'd0,  "spot_0_0");
        lookup4(4'd8,  4'd9,  "spot_8_9");
        tick();
        check("idle_hold", {26'd0, s4.sum_valid, s4.sum}, 32'(exp_sum));
        rand_phase4(40);

        s4.start = 1'b1;
        tick();
        s4.start = 1'b0;
        for (int k = 0; k < 300 && s4.fill_addr !== 8'd100; k++) tick();
        check("reached_addr_100", {24'd0, s4.fill_addr}, 32'd100);
        #2;
        rst4 = 1'b1;
        #1;
        check("async_reset_outputs",
              {17'd0, s4.busy, s4.ready, s4.done, s4.sum_valid, s4.fill_addr, s4.sum}, 32'd0);
        tick();
        rst4 = 1'b0;
        model_ready = 1'b0;
        exp_sum = 0;
        rand_phase4(10);
        fill4(1'b0, -1);
        lookup4(4'd8, 4'd9, "post_reset_8_9");
        rand_phase4(30);
        fill4(1'b1, -1);
        rand_phase4(30);

        s1.start = 1'b1;
        tick();
        s1.start = 1'b0;
        done1 = -1; ready1 = -1;
        for (int k = 1; k <= 20; k++) begin
            if (s1.done === 1'b1) done1 = k;
            if (s1.ready === 1'b1) begin ready1 = k; break; end
            tick();
        end
        check("w1_done_cycle",  32'(done1),  32'd4);
        check("w1_ready_cycle", 32'(ready1), 32'd5);
        for (int i = 0; i < 4; i++) begin
            p1 = 2'(i);
            s1.rd_en = 1'b1; s1.a = p1[1]; s1.b = p1[0];
            tick();
            check("w1_lookup", {29'd0, s1.sum_valid, s1.sum}, 32'(4 + int'(p1[1]) + int'(p1[0])));
        end
        s1.rd_en = 1'b0;

        for (int k = 0; k < 70000 && s8.ready !== 1'b1; k++) tick();
        check("w8_ready",      {31'd0, s8.ready}, 32'd1);
        check("w8_done_count", 32'(n_done8),      32'd1);
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin ra8 = 8'd255; rb8 = 8'd255; end
                1: begin ra8 = 8'd0;   rb8 = 8'd0;   end
                2: begin ra8 = 8'd128; rb8 = 8'd127; end
                default: begin ra8 = 8'($urandom); rb8 = 8'($urandom); end
            endcase
            s8.rd_en = 1'b1; s8.a = ra8; s8.b = rb8;
            tick();
            check("w8_lookup", {22'd0, s8.sum_valid, s8.sum}, 32'(512 + int'(ra8) + int'(rb8)));
        end
        s8.rd_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sum_table_writer.md
Name: sum_table_writer

Overview:
- Writer side of the ROM-style adder lookup. A sequential FSM sweeps every {a,b} operand pair and writes a+b into an internal synchronous RAM.
- Once the table is complete, it serves registered lookups, so sum values come from a table this block built rather than from a precomputed ROM image.
- Sits beside the lookup-adder datapath as the table builder/refresher; downstream logic reads sums through the lookup port.

Parameters:
- DATA_WIDTH, 4, operand width; table depth is 2**(2*DATA_WIDTH) entries, each DATA_WIDTH+1 bits; legal range 1..8.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a (re)fill of the whole table.
- busy  output  1  high while filling.
- ready  output  1  high when the table is complete and lookups are served.
- done  output  1  one-cycle pulse when the last entry is written.
- fill_addr  output  2*DATA_WIDTH  current write index, {a,b}.
- rd_en  input  1  lookup request.
- a  input  DATA_WIDTH  lookup operand, high address half.
- b  input  DATA_WIDTH  lookup operand, low address half.
- sum  output  DATA_WIDTH+1  looked-up sum.
- sum_valid  output  1  sum is valid this cycle.

Behaviour:
- Reset, asynchronous, any state: state=EMPTY; busy=0, ready=0, done=0, fill_addr=0, sum=0, sum_valid=0.
- RAM contents are not reset and are treated as invalid until a full fill completes.

State EMPTY:
- start=1 -> FILL at the next edge, with fill_addr=0 and busy=1.

State FILL:
- Each cycle, write mem[fill_addr] = {1'b0, fill_addr[2W-1:W]} + {1'b0, fill_addr[W-1:0]}, zero-extended to W+1 bits with no truncation, then increment fill_addr.
- On the cycle the entry at fill_addr = all-ones is written: next state READY, done=1 for exactly one cycle, busy=0, ready=1, fill_addr wraps to 0.
- A fill takes exactly 2**(2W) cycles from the first FILL cycle.
- start during FILL is ignored; there is no restart.

State READY:
- start=1 -> FILL. ready drops the next cycle and the whole table is rewritten from entry 0.
- A lookup accepted in that same start cycle is still served.

Lookup:
- Accepted when rd_en=1 and ready=1 at edge N.
- sum = mem[{a,b}] and sum_valid=1 at edge N+1, i.e. 1-cycle latency.
- Back-to-back lookups at one per cycle are supported.
- rd_en while ready=0 is dropped: sum_valid=0 and sum holds its value. There is no queueing.
- sum_valid is low in any cycle without an accepted lookup; sum holds its last value.

Reset mid-FILL:
- Aborts immediately to EMPTY with ready=0.
- A new start is required; the partial table is never exposed.

Simultaneous events:
- Reset dominates everything.
- In FILL, the write has priority and rd_en is ignored.
- The RAM uses write-first semantics, but this is never observable because reads are blocked during FILL.

Decomposition:
- Package sum_table_pkg holds:
  - typedef enum state_t {EMPTY, FILL, READY};
  - function addr_w(DATA_WIDTH) = 2*DATA_WIDTH;
  - function depth(DATA_WIDTH) = 2**(2*DATA_WIDTH).
- Sub-module sum_table_ram: simple dual-port synchronous RAM with one write port, one registered read port, and parameters for address and data width.
- The FSM, address counter and adder live in the top module.

Test Plan (DATA_WIDTH=4 unless stated):
- Fill timing: reset, then start pulse at cycle 0 -> busy=1 from cycle 1; done pulses once at cycle 256; ready=1 from cycle 257; fill_addr back to 0.
- Exhaustive check: after ready, issue back-to-back lookups over all 256 {a,b} pairs -> each sum equals a+b one cycle later with sum_valid=1. Spot values: a=15,b=15 -> 5'b11110; a=0,b=0 -> 0; a=8,b=9 -> 17.
- Blocked reads: rd_en=1 with a=3,b=4 during FILL and in EMPTY -> sum_valid stays 0 and sum unchanged.
- Reset mid-fill: assert rst when fill_addr=100 -> outputs return to reset values asynchronously; state EMPTY; new start -> full 256-cycle fill; data correct afterwards.
- Refill and ignored start: start during FILL -> done still at cycle 256, not extended. start in READY together with rd_en a=7,b=9 -> sum=16 valid next cycle; ready low after; done 256 cycles later.
- Width corner: DATA_WIDTH=1 -> 4-entry table, done after 4 cycles, lookups 1+1 -> 2'b10; DATA_WIDTH=8 -> a=255,b=255 -> 9'b111111110.
